// File: rtl/bistable_drv_pkg.sv
// Shared types and widths for the bistable flip-flop pulse sequencer.
package bistable_drv_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    OP_NOP         = 3'd0,
    OP_SET_LEFT    = 3'd1,
    OP_SET_RIGHT   = 3'd2,
    OP_COMPLEMENT  = 3'd3,
    OP_DCRST_LEFT  = 3'd4,
    OP_DCRST_RIGHT = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DCRST,
    ST_CHECK,
    ST_RESP
  } state_e;

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; zero is high once the loaded count has run out.
module pulse_timer
  import bistable_drv_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - TIMER_W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/bistable_driver.sv
// Command sequencer producing gate / AC-set / DC-reset pulses for one bistable
// and returning a checked readback of its b output.
module bistable_driver
  import bistable_drv_pkg::*;
#(
  parameter int GATE_SETUP     = 2,
  parameter int PULSE_WIDTH    = 1,
  parameter int RECOVERY       = 2,
  parameter int DC_RESET_WIDTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  output logic       ac_set_left,
  output logic       gate_left,
  output logic       ac_set_right,
  output logic       gate_right,
  output logic       reset_left,
  output logic       reset_right,
  input  logic       b_i,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_err,
  output logic       resp_b,
  output logic       resp_changed
);

  if (GATE_SETUP < 1 || GATE_SETUP > 255 || PULSE_WIDTH < 1 || PULSE_WIDTH > 255 ||
      RECOVERY < 1 || RECOVERY > 255 || DC_RESET_WIDTH < 1 || DC_RESET_WIDTH > 255)
  begin : g_bad_timing
    $error("bistable_driver: timing parameters must lie in 1..255");
  end

  state_e             state_reg, state_next;
  op_e                op_in;
  logic               side_right_reg;  // 1: right side is driven
  logic               dc_reg;          // current op is a DC reset (no gate in HOLD)
  logic               expected_reg;
  logic               b0_reg;
  logic               resp_err_reg, resp_b_reg, resp_changed_reg;
  logic               accept;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_val;
  logic               timer_zero;

  assign op_in     = op_e'(cmd_op);
  assign cmd_ready = (state_reg == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;

  pulse_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .zero     (timer_zero)
  );

  always_comb begin
    state_next     = state_reg;
    timer_load     = 1'b0;
    timer_load_val = '0;
    unique case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op_in)
            OP_SET_LEFT, OP_SET_RIGHT, OP_COMPLEMENT: begin
              state_next     = ST_SETUP;
              timer_load     = 1'b1;
              timer_load_val = TIMER_W'(GATE_SETUP - 1);
            end
            OP_DCRST_LEFT, OP_DCRST_RIGHT: begin
              state_next     = ST_DCRST;
              timer_load     = 1'b1;
              timer_load_val = TIMER_W'(DC_RESET_WIDTH - 1);
            end
            default: state_next = ST_RESP;
          endcase
        end
      end
      ST_SETUP: begin
        if (timer_zero) begin
          state_next     = ST_PULSE;
          timer_load     = 1'b1;
          timer_load_val = TIMER_W'(PULSE_WIDTH - 1);
        end
      end
      ST_PULSE, ST_DCRST: begin
        if (timer_zero) begin
          state_next     = ST_HOLD;
          timer_load     = 1'b1;
          timer_load_val = TIMER_W'(RECOVERY - 1);
        end
      end
      ST_HOLD:  if (timer_zero) state_next = ST_CHECK;
      ST_CHECK: state_next = ST_RESP;
      ST_RESP:  if (resp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      side_right_reg   <= 1'b0;
      dc_reg           <= 1'b0;
      expected_reg     <= 1'b0;
      b0_reg           <= 1'b0;
      resp_err_reg     <= 1'b0;
      resp_b_reg       <= 1'b0;
      resp_changed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        b0_reg <= b_i;
        dc_reg <= (op_in == OP_DCRST_LEFT) || (op_in == OP_DCRST_RIGHT);
        case (op_in)
          OP_SET_LEFT, OP_DCRST_LEFT: begin
            side_right_reg <= 1'b0;
            expected_reg   <= 1'b0;
          end
          OP_SET_RIGHT, OP_DCRST_RIGHT: begin
            side_right_reg <= 1'b1;
            expected_reg   <= 1'b1;
          end
          OP_COMPLEMENT: begin
            // Left set drives b to 0, so a set b is complemented from the left.
            side_right_reg <= !b_i;
            expected_reg   <= !b_i;
          end
          default: begin
            side_right_reg   <= 1'b0;
            expected_reg     <= b_i;
            resp_b_reg       <= b_i;
            resp_err_reg     <= (op_in != OP_NOP);
            resp_changed_reg <= 1'b0;
          end
        endcase
      end else if (state_reg == ST_CHECK) begin
        resp_b_reg       <= b_i;
        resp_err_reg     <= (b_i != expected_reg);
        resp_changed_reg <= (b_i != b0_reg);
      end
    end
  end

  always_comb begin
    ac_set_left  = 1'b0;
    gate_left    = 1'b0;
    ac_set_right = 1'b0;
    gate_right   = 1'b0;
    reset_left   = 1'b0;
    reset_right  = 1'b0;
    unique case (state_reg)
      ST_SETUP, ST_HOLD: begin
        gate_left  = !dc_reg && !side_right_reg;
        gate_right = !dc_reg && side_right_reg;
      end
      ST_PULSE: begin
        gate_left    = !side_right_reg;
        ac_set_left  = !side_right_reg;
        gate_right   = side_right_reg;
        ac_set_right = side_right_reg;
      end
      ST_DCRST: begin
        reset_left  = !side_right_reg;
        reset_right = side_right_reg;
      end
      default: ;
    endcase
  end

  assign resp_valid   = (state_reg == ST_RESP);
  assign resp_err     = resp_err_reg;
  assign resp_b       = resp_b_reg;
  assign resp_changed = resp_changed_reg;

endmodule

// File: tb/tb_bistable_driver.sv
// Randomized bench: a bistable model answers the DUT's pulses and a timing model
// predicts every drive cycle and response.
module tb_bistable_driver;

  localparam int GS = 2;
  localparam int PW = 1;
  localparam int RC = 2;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic       ac_set_left, gate_left, ac_set_right, gate_right;
  logic       reset_left, reset_right;
  logic       b_i;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic       resp_err, resp_b, resp_changed;

  logic       bist;
  logic       stuck_en = 1'b0;
  logic       stuck_val = 1'b0;
  logic [5:0] drive;
  int         n_vec = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  bistable_driver #(
    .GATE_SETUP     (GS),
    .PULSE_WIDTH    (PW),
    .RECOVERY       (RC),
    .DC_RESET_WIDTH (DC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .ac_set_left  (ac_set_left),
    .gate_left    (gate_left),
    .ac_set_right (ac_set_right),
    .gate_right   (gate_right),
    .reset_left   (reset_left),
    .reset_right  (reset_right),
    .b_i          (b_i),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_err     (resp_err),
    .resp_b       (resp_b),
    .resp_changed (resp_changed)
  );

  // Left/right bistable: left set or left DC reset gives b=0, right gives b=1.
  always @(posedge clk) begin
    if (reset) bist <= 1'b1;
    else if (reset_left) bist <= 1'b0;
    else if (reset_right) bist <= 1'b1;
    else if (gate_left && ac_set_left) bist <= 1'b0;
    else if (gate_right && ac_set_right) bist <= 1'b1;
  end

  assign b_i   = stuck_en ? stuck_val : bist;
  assign drive = {ac_set_left, gate_left, ac_set_right, gate_right, reset_left, reset_right};

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected drive vector for cycle c after acceptance (c=1 is the cycle after the accept edge).
  function automatic logic [5:0] exp_drive(input logic [2:0] op, input logic side_r, input int c);
    logic gate, ac, rst;
    gate = 1'b0; ac = 1'b0; rst = 1'b0;
    if (op >= 3'd1 && op <= 3'd3) begin
      gate = (c <= GS + PW + RC);
      ac   = (c > GS) && (c <= GS + PW);
    end else if (op == 3'd4 || op == 3'd5) begin
      rst = (c <= DC);
    end
    return side_r ? {2'b00, ac, gate, 1'b0, rst} : {ac, gate, 2'b00, rst, 1'b0};
  endfunction

  task automatic run_cmd(input logic [2:0] op, input int hold);
    logic b0, side_r, tgt, exp_b, exp_err, exp_chg;
    int   busy;
    @(negedge clk);
    chk("idle_ready", int'(cmd_ready), 1);
    chk("idle_resp_valid", int'(resp_valid), 0);
    chk("idle_drive", int'(drive), 0);
    b0 = b_i;
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    case (op)
      3'd1, 3'd4: begin side_r = 1'b0; tgt = 1'b0; end
      3'd2, 3'd5: begin side_r = 1'b1; tgt = 1'b1; end
      3'd3:       begin side_r = !b0;  tgt = !b0;  end
      default:    begin side_r = 1'b0; tgt = b0;   end
    endcase
    if (op >= 3'd1 && op <= 3'd3) busy = GS + PW + RC + 1;
    else if (op == 3'd4 || op == 3'd5) busy = DC + RC + 1;
    else busy = 0;
    if (busy != 0) begin
      exp_b   = stuck_en ? stuck_val : tgt;
      exp_err = (exp_b != tgt);
      exp_chg = (exp_b != b0);
    end else begin
      exp_b   = b0;
      exp_err = (op != 3'd0);
      exp_chg = 1'b0;
    end
    for (int c = 1; c <= busy; c++) begin
      @(negedge clk);
      chk($sformatf("drive_op%0d_c%0d", op, c), int'(drive), int'(exp_drive(op, side_r, c)));
      chk("busy_ready", int'(cmd_ready), 0);
      chk("busy_resp_valid", int'(resp_valid), 0);
      // Commands offered while busy must be ignored.
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 3'($urandom_range(0, 7));
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("resp_valid", int'(resp_valid), 1);
      chk("resp_b", int'(resp_b), int'(exp_b));
      chk("resp_err", int'(resp_err), int'(exp_err));
      chk("resp_changed", int'(resp_changed), int'(exp_chg));
      chk("resp_drive", int'(drive), 0);
      chk("resp_ready_low", int'(cmd_ready), 0);
      resp_ready = (h == hold);
    end
    @(posedge clk);
    #1 resp_ready = 1'b0;
    $display("op=%0d b0=%0d hold=%0d -> resp b=%0d err=%0d changed=%0d (want %0d/%0d/%0d)",
             op, b0, hold, resp_b, resp_err, resp_changed, exp_b, exp_err, exp_chg);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_drive", int'(drive), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_fields", int'({resp_b, resp_err, resp_changed}), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_cmd(3'd1, 0);   // b=1 -> left set, changed
    run_cmd(3'd1, 0);   // already 0
    run_cmd(3'd3, 0);   // complement from 0 -> right
    run_cmd(3'd3, 0);   // complement from 1 -> left
    run_cmd(3'd3, 0);
    run_cmd(3'd1, 0);
    run_cmd(3'd5, 0);   // DC reset right from b=0
    run_cmd(3'd4, 1);
    stuck_en = 1'b1; stuck_val = 1'b1;
    run_cmd(3'd1, 0);   // stuck at 1 -> err
    stuck_en = 1'b0;
    run_cmd(3'd7, 0);
    run_cmd(3'd6, 0);
    run_cmd(3'd0, 0);
    run_cmd(3'd2, 5);   // long response stall

    // Reset in the middle of a SET_RIGHT pulse.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_pulse_drive", int'(drive), int'(6'b001100));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_drive", int'(drive), 0);
    chk("mid_rst_resp_valid", int'(resp_valid), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_ready", int'(cmd_ready), 1);
      chk("post_rst_resp_valid", int'(resp_valid), 0);
      chk("post_rst_drive", int'(drive), 0);
    end
    $display("reset during SET_RIGHT pulse: outputs cleared, no response");

    for (int n = 0; n < 40; n++) begin
      stuck_en  = ($urandom_range(0, 5) == 0);
      stuck_val = 1'($urandom_range(0, 1));
      run_cmd(3'($urandom_range(0, 7)), $urandom_range(0, 3));
    end
    stuck_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bistable_driver.md
Name: bistable_driver

Overview:
- Command-driven sequencer that generates the gate levels, AC-set pulses and DC-reset pulses consumed by one left/right bistable flip-flop.
- After each operation it reads the bistable's b output back and returns a checked response.
- Sits between a controller (or test bench) and one bistable; it is the pulse source for that flip-flop's set, gate and reset inputs.

Parameters:
- GATE_SETUP, 2, cycles the gate is high before the AC-set pulse (1..255)
- PULSE_WIDTH, 1, cycles the AC-set pulse is high (1..255)
- RECOVERY, 2, cycles the gate is held after the pulse falls, or idle cycles after a DC reset (1..255)
- DC_RESET_WIDTH, 3, cycles a DC-reset level is high (1..255)

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  3  0 NOP, 1 SET_LEFT, 2 SET_RIGHT, 3 COMPLEMENT, 4 DCRST_LEFT, 5 DCRST_RIGHT, 6-7 illegal
- ac_set_left  out  1  AC-set pulse, left side
- gate_left  out  1  gate level, left side
- ac_set_right  out  1  AC-set pulse, right side
- gate_right  out  1  gate level, right side
- reset_left  out  1  DC-reset level, left; the bistable ends with b=0
- reset_right  out  1  DC-reset level, right; the bistable ends with b=1
- b_i  in  1  bistable b readback, same clock domain
- resp_valid  out  1  response available
- resp_ready  in  1  response consumed
- resp_err  out  1  readback mismatch, or illegal op
- resp_b  out  1  b_i sampled in CHECK
- resp_changed  out  1  resp_b differs from b_i captured at accept

Behaviour:
- Reset: on the edge where reset is high, every output except cmd_ready goes to 0 and the FSM goes to IDLE. cmd_ready=1 from the first cycle after reset deasserts. Reset mid-operation drops gates, pulses and DC-reset levels on the same edge and discards any pending response.
- Accept: occurs on an edge with cmd_valid&&cmd_ready. The block latches op, b0=b_i and the expected value. Expected: SET_LEFT→0, SET_RIGHT→1, COMPLEMENT→!b0, DCRST_LEFT→0, DCRST_RIGHT→1.
- Side selection: SET_LEFT uses the left side and SET_RIGHT the right. COMPLEMENT uses left if b0=1, else right.
- FSM states: IDLE, SETUP, PULSE, HOLD, DCRST, CHECK, RESP.
- IDLE→SETUP for ops 1-3; IDLE→DCRST for ops 4-5; IDLE→RESP for NOP and illegal ops.
- SETUP: gate of the chosen side high for GATE_SETUP cycles, then PULSE.
- PULSE: gate high and ac_set of the same side high for PULSE_WIDTH cycles, then HOLD.
- HOLD: gate high, ac_set low, for RECOVERY cycles, then CHECK.
- DCRST: reset_left or reset_right high for DC_RESET_WIDTH cycles, then HOLD with no gate for RECOVERY cycles.
- CHECK: 1 cycle, all drive outputs low, samples b_i into resp_b, computes resp_err=(b_i!=expected) and resp_changed=(b_i!=b0). Then RESP.
- RESP: resp_valid high and resp_* stable until resp_valid&&resp_ready, then IDLE. cmd_ready rises the cycle after the handshake.
- Back-to-back rate: at most one command every GATE_SETUP+PULSE_WIDTH+RECOVERY+3 cycles.
- NOP response: err=0, resp_b=b0, changed=0.
- Illegal-op response: err=1, resp_b=b0, changed=0. No output toggles.
- Exclusivity: never more than one of the six drive outputs' sides active at once. Left and right are never both active. ac_set is never high without its gate high.
- Latency, defaults, edge 0 = accept:
  - cycles 1-2: gate only
  - cycle 3: gate+ac_set
  - cycles 4-5: gate only
  - cycle 6: CHECK
  - cycle 7: resp_valid
- Already-in-state: SET_LEFT with b0=0 still sequences fully. The response is err=0, changed=0.
- Counters: one shared 8-bit down-counter, loaded with parameter-1 on state entry; the state exits when the count is 0. Parameter value 0 is illegal and is flagged by an elaboration assertion.
- cmd_valid while busy is ignored. The command is not latched.

Decomposition:
- Package bistable_drv_pkg: op_e (3-bit opcode enum), state_e FSM enum, TIMER_W=8.
- Sub-module pulse_timer: loadable 8-bit down-counter with load, load_val, and a zero flag. The FSM instantiates it once.

Test Plan:
- Defaults, b_i modelled by a bistable starting at 1, SET_LEFT → gate_left high cycles 1-5, ac_set_left high cycle 3 only; resp at cycle 7 with err=0, b=0, changed=1.
- b=0, SET_LEFT → full sequence on the left side; resp err=0, b=0, changed=0.
- COMPLEMENT twice from b=1 → first on the left side (b→0), second on the right side (b→1); both responses err=0, changed=1.
- DCRST_RIGHT from b=0 → reset_right high cycles 1-3, no gates; resp at cycle 7 with b=1, err=0.
- b_i stuck at 1, SET_LEFT → resp err=1, b=1. Op 7 → resp err=1 the cycle after accept, with no drive-output activity.
- Reset asserted at cycle 3 of SET_RIGHT → all outputs 0 on that edge, no resp_valid, cmd_ready=1 after release. resp_ready held low for 5 cycles → resp fields stable and cmd_ready=0 throughout.
